// File: rtl/pattern_detect_ctrl.sv
// Run controller for a programmable serial pattern detector with hit counting, target and timeout.
// Optional build macro NONOVERLAP_EN: clear history on each hit so hits cannot share bits.
module pattern_detect_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic             in,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] PAT_W5 = 5'(PAT_W);

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [3:0]       len_q;
    logic [CNT_W-1:0] tgt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [PAT_W-1:0] hist_q;
    logic [3:0]       bits_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0] tcnt_q;
    logic             match_q;
    logic             done_q;
    logic             terr_q;

    logic             cfg_open;
    logic [3:0]       eff_len;
    logic             start_ok;
    logic             accept;
    logic [PAT_W-1:0] hist_d;
    logic [3:0]       bits_d;
    logic [CNT_W-1:0] cnt_d;
    logic [TMO_W-1:0] tcnt_d;
    logic [PAT_W-1:0] mask;
    logic             hit;
    logic             tgt_hit;
    logic             tmo_hit;

    always_comb begin
        cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);
        // A same-cycle cfg write decides whether start is honoured.
        eff_len  = (cfg_we && cfg_open) ? cfg_len : len_q;
        start_ok = start && cfg_open && (eff_len != 4'd0) && ({1'b0, eff_len} <= PAT_W5);

        accept = in_valid && (state_q == S_RUN);
        hist_d = {hist_q[PAT_W-2:0], in};
        bits_d = (bits_q >= len_q) ? bits_q : bits_q + 4'd1;

        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_q));
        end

        hit = accept
              && (({1'b0, bits_q} + 5'd1) >= {1'b0, len_q})
              && ((hist_d & mask) == (pat_q & mask));

        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        tcnt_d  = tcnt_q + 1'b1;
        tgt_hit = hit && (tgt_q != '0) && (cnt_d == tgt_q);
        tmo_hit = !hit && (tmo_q != '0) && (tcnt_d == tmo_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            tmo_q   <= '0;
            hist_q  <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            match_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        tgt_q <= cfg_target;
                        tmo_q <= cfg_timeout;
                    end
                    // Run state is cleared on entry so ARM already shows a clean slate.
                    if (start_ok) begin
                        state_q <= S_ARM;
                        hist_q  <= '0;
                        bits_q  <= '0;
                        cnt_q   <= '0;
                        tcnt_q  <= '0;
                        done_q  <= 1'b0;
                        terr_q  <= 1'b0;
                    end
                end
                S_ARM: begin
                    state_q <= stop ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (accept) begin
                        hist_q <= hist_d;
                        bits_q <= bits_d;
                    end
                    if (hit) begin
                        match_q <= 1'b1;
                        cnt_q   <= cnt_d;
                        tcnt_q  <= '0;
`ifdef NONOVERLAP_EN
                        hist_q  <= '0;
                        bits_q  <= '0;
`else
`endif
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (tgt_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        terr_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign busy        = (state_q == S_ARM) || (state_q == S_RUN);
    assign match       = match_q;
    assign match_cnt   = cnt_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed self-checking bench for pattern_detect_ctrl (default PAT_W=4, CNT_W=8, TMO_W=16).
module tb_pattern_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic [7:0]  cfg_target = '0;
    logic [15:0] cfg_timeout = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in = 1'b0;
    logic        in_ready;
    logic        match;
    logic [7:0]  match_cnt;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    pattern_detect_ctrl #(.PAT_W(4), .CNT_W(8), .TMO_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .start(start), .stop(stop), .in_valid(in_valid), .in(in),
        .in_ready(in_ready), .match(match), .match_cnt(match_cnt), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_run(input logic [3:0] pat, input logic [3:0] len,
                           input logic [7:0] tgt, input logic [15:0] tmo);
        cfg_pattern = pat; cfg_len = len; cfg_target = tgt; cfg_timeout = tmo;
        cfg_we = 1'b1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1; in = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in = 1'b1;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({in_ready, match, busy, done, timeout_err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, match, busy, done, timeout_err}); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        cfg_pattern = 4'b0110; cfg_len = 4'd0; cfg_we = 1'b1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b expected 0", busy); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL len0_ready: got %b expected 0", in_ready); end
        cfg_len = 4'd5; cfg_we = 1'b1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len5_busy: got %b expected 0", busy); end
    endtask

    task automatic test_target();
        logic seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        arm_run(4'b0110, 4'd3, 8'd2, 16'd0);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL tgt_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            send_bit(seq[i]);
            n_cmp++; if (match !== exp[i]) begin n_bad++; $display("FAIL tgt_match bit%0d: got %b expected %b", i + 1, match, exp[i]); end
        end
        n_cmp++; if ({done, in_ready, timeout_err} !== 3'b100) begin n_bad++; $display("FAIL tgt_done: got done/ready/terr %b expected 100", {done, in_ready, timeout_err}); end
        n_cmp++; if (match_cnt !== 8'd2) begin n_bad++; $display("FAIL tgt_cnt: got %0d expected 2", match_cnt); end
        tick();
        n_cmp++; if ({done, match} !== 2'b10) begin n_bad++; $display("FAIL tgt_hold: got done/match %b expected 10", {done, match}); end
    endtask

    task automatic test_overlap();
        logic seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   hits = 0;
        int   exp_hits;
`ifdef NONOVERLAP_EN
        exp_hits = 1;
`else
        exp_hits = 2;
`endif
        arm_run(4'b0101, 4'd3, 8'd0, 16'd0);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ovl_done_cleared: got %b expected 0", done); end
        for (int i = 0; i < 5; i++) begin
            send_bit(seq[i]);
            if (match === 1'b1) hits++;
        end
        n_cmp++; if (hits !== exp_hits) begin n_bad++; $display("FAIL ovl_hits: got %0d expected %0d", hits, exp_hits); end
        n_cmp++; if (match_cnt !== 8'(exp_hits)) begin n_bad++; $display("FAIL ovl_cnt: got %0d expected %0d", match_cnt, exp_hits); end
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovl_stop: got busy %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int n = 0;
        arm_run(4'b0110, 4'd3, 8'd1, 16'd5);
        in_valid = 1'b1; in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) break;
            if (in_ready === 1'b1) n++;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL tmo_cycles: got %0d expected 5", n); end
        n_cmp++; if ({done, timeout_err} !== 2'b11) begin n_bad++; $display("FAIL tmo_flags: got %b expected 11", {done, timeout_err}); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL tmo_cnt: got %0d expected 0", match_cnt); end
        // hit on the would-be timeout cycle clears the counter
        arm_run(4'b0010, 4'd2, 8'd0, 16'd2);
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_terr_cleared: got %b expected 0", timeout_err); end
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++; if ({match, done} !== 2'b10) begin n_bad++; $display("FAIL tmo_hit_wins: got match/done %b expected 10", {match, done}); end
        send_bit(1'b0);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got done %b expected 0", done); end
        send_bit(1'b0);
        n_cmp++; if ({done, timeout_err, match_cnt} !== {2'b11, 8'd1}) begin n_bad++; $display("FAIL tmo_after_hit: got done/terr %b cnt %0d expected 11 cnt 1", {done, timeout_err}, match_cnt); end
    endtask

    task automatic test_gaps();
        logic vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic bt  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        arm_run(4'b0110, 4'd3, 8'd0, 16'd0);
        for (int i = 0; i < 7; i++) begin
            in_valid = vld[i]; in = bt[i];
            cfg_we = (i == 2); cfg_pattern = 4'b0011;
            tick();
            cfg_we = 1'b0;
            n_cmp++; if (match !== exp[i]) begin n_bad++; $display("FAIL gap_match step%0d: got %b expected %b", i, match, exp[i]); end
        end
        in_valid = 1'b0;
        n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic test_stop_rst();
        arm_run(4'b0110, 4'd3, 8'd0, 16'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if ({busy, done, in_ready} !== 3'b000) begin n_bad++; $display("FAIL stop_idle: got busy/done/ready %b expected 000", {busy, done, in_ready}); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL stop_cnt: got %0d expected 0", match_cnt); end
        arm_run(4'b0110, 4'd3, 8'd0, 16'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        stop = 1'b1; send_bit(1'b0); stop = 1'b0;
        n_cmp++; if ({match, busy, match_cnt} !== {2'b10, 8'd1}) begin n_bad++; $display("FAIL stop_hit: got match/busy %b cnt %0d expected 10 cnt 1", {match, busy}, match_cnt); end
        arm_run(4'b0110, 4'd3, 8'd0, 16'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1; in_valid = 1'b1; in = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({in_ready, match, busy, done, timeout_err, match_cnt} !== 13'd0) begin n_bad++; $display("FAIL midrun_rst: got flags %b cnt %0d expected 00000 cnt 0", {in_ready, match, busy, done, timeout_err}, match_cnt); end
    endtask

    initial begin
        test_reset();
        test_target();
        test_overlap();
        test_timeout();
        test_gaps();
        test_stop_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
